// File: rtl/fuse_key_loader_if.sv
// Key stream from fuse_key_loader to its consumer: valid/ready handshake carrying one fuse word.
// A word moves on a rising edge where key_valid and key_ready are both high; the source holds it stable until then.
interface fuse_key_loader_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 3
);
    logic              key_valid;
    logic              key_ready;
    logic [DATA_W-1:0] key_data;
    logic [DEST_W-1:0] key_dest;
    logic              key_last;

    modport master (output key_valid, key_data, key_dest, key_last, input key_ready);
    modport slave  (input key_valid, key_data, key_dest, key_last, output key_ready);
endinterface

// File: rtl/fuse_key_loader.sv
// Reads a slice of fuse words (highest index first) and streams them to one consumer.
// Optional FUSE_KEY_LOADER_LOCK_EN makes each destination loadable only once per reset.
module fuse_key_loader #(
    parameter int DATA_W    = 32,
    parameter int MEM_SIZE  = 108,
    parameter int ADDR_W    = 7,
    parameter int MAX_WORDS = 16,
    parameter int DEST_W    = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [4:0]        req_len_i,
    input  logic [DEST_W-1:0] req_dest_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] fuse_addr_o,
    input  logic [DATA_W-1:0] fuse_data_i,
    fuse_key_loader_if.master key,
    output logic [2:0]        dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_READ  = 3'd2,
        S_CAPT  = 3'd3,
        S_SEND  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        len_q, len_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [ADDR_W-1:0] fuse_addr_q, fuse_addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done, err, reject;
    logic [ADDR_W:0]   addr_ext, len_ext;

`ifdef FUSE_KEY_LOADER_LOCK_EN
    logic [(2**DEST_W)-1:0] lock_q, lock_d;
`endif

    // Widened compare so addr+1 cannot wrap; addr+1 < len means the slice would run below index 0.
    assign addr_ext = {1'b0, addr_q};
    assign len_ext  = (ADDR_W+1)'(len_q);

    always_comb begin
        reject = (len_q == 5'd0) || (len_q > 5'(MAX_WORDS)) ||
                 (addr_ext >= (ADDR_W+1)'(MEM_SIZE)) ||
                 ((addr_ext + (ADDR_W+1)'(1)) < len_ext);
`ifdef FUSE_KEY_LOADER_LOCK_EN
        if (lock_q[dest_q]) reject = 1'b1;
`endif
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        dest_d      = dest_q;
        fuse_addr_d = fuse_addr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        done        = 1'b0;
        err         = 1'b0;
`ifdef FUSE_KEY_LOADER_LOCK_EN
        lock_d      = lock_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    addr_d  = req_addr_i;
                    len_d   = req_len_i;
                    dest_d  = req_dest_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (reject) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    fuse_addr_d = addr_q;
                    state_d     = S_READ;
                end
            end
            S_READ: state_d = S_CAPT;
            S_CAPT: begin
                data_d  = fuse_data_i;
                valid_d = 1'b1;
                last_d  = (len_q == 5'd1);
                state_d = S_SEND;
            end
            S_SEND: begin
                if (key.key_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d      = addr_q - ADDR_W'(1);
                        len_d       = len_q - 5'd1;
                        fuse_addr_d = addr_q - ADDR_W'(1);
                        state_d     = S_READ;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                data_d  = '0;
`ifdef FUSE_KEY_LOADER_LOCK_EN
                lock_d[dest_q] = 1'b1;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            dest_q      <= '0;
            fuse_addr_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
`ifdef FUSE_KEY_LOADER_LOCK_EN
            lock_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            dest_q      <= dest_d;
            fuse_addr_q <= fuse_addr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
`ifdef FUSE_KEY_LOADER_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done;
    assign err_o         = err;
    assign fuse_addr_o   = fuse_addr_q;
    assign key.key_valid = valid_q;
    assign key.key_data  = data_q;
    assign key.key_dest  = dest_q;
    assign key.key_last  = last_q;
    assign dbg_state_o   = state_q;
endmodule

// File: doc/fuse_key_loader.md
Name: fuse_key_loader

Overview:
- Sequential reader placed directly downstream of the fuse memory.
- Accepts a load command (start word index, word count, destination ID) and reads fuse words one per access over a 1-cycle-latency address/data port.
- Streams the words to crypto/access-control consumers over a valid/ready interface.
- Keys never leave fuse storage in bulk; each consumer receives only its requested slice, most-significant word first.

Parameters:
- DATA_W, 32, fuse word width.
- MEM_SIZE, 108, number of fuse words; valid indices 0..MEM_SIZE-1.
- ADDR_W, 7, width of fuse word index (>= clog2(MEM_SIZE)).
- MAX_WORDS, 16, maximum words per load command.
- DEST_W, 3, width of destination ID.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- req_i  in  1  load request; accepted only in IDLE.
- req_addr_i  in  ADDR_W  index of the first (most-significant) word; later words use decreasing indices.
- req_len_i  in  5  word count, 1..MAX_WORDS.
- req_dest_i  in  DEST_W  consumer ID, echoed on key_dest_o.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  one-cycle pulse on rejected command.
- fuse_addr_o  out  ADDR_W  fuse word index; data returns on fuse_data_i the following cycle.
- fuse_data_i  in  DATA_W  fuse read data.
- key_valid_o  out  1  key word valid.
- key_ready_i  in  1  consumer ready.
- key_data_o  out  DATA_W  key word.
- key_dest_o  out  DEST_W  destination of the current command.
- key_last_o  out  1  high with the final word of the command.

Behaviour:
- Clocking and reset:
  - Single clock, clk_i.
  - rst_ni is synchronous, active-low, sampled on the rising edge.
  - Reset mid-operation aborts the command: no done_o or err_o is issued, and key_valid_o drops at that same edge.
- Reset values: state=IDLE; busy_o, done_o, err_o, key_valid_o, key_last_o = 0; fuse_addr_o, key_data_o, key_dest_o = 0; word counter = 0.
- FSM states: IDLE, CHECK, READ, CAPT, SEND, DONE.
- IDLE:
  - On req_i=1, register addr/len/dest and go to CHECK.
  - req_i in any other state is ignored (not queued).
- CHECK (1 cycle): if len==0, len>MAX_WORDS, req_addr_i>=MEM_SIZE, or req_addr_i<len-1 (index underflow):
  - Pulse err_o for one cycle and return to IDLE.
  - No fuse_addr_o change and no key_valid_o.
  - Otherwise go to READ.
- READ: drive fuse_addr_o=cur_addr; go to CAPT.
- CAPT:
  - Capture fuse_data_i into key_data_o.
  - Set key_valid_o=1; set key_last_o=1 if remaining==1; go to SEND.
- SEND:
  - key_valid_o, key_data_o, key_dest_o and key_last_o hold stable until key_ready_i=1.
  - On handshake (valid & ready at the edge): drop key_valid_o.
  - If last word, go to DONE; otherwise cur_addr--, remaining--, go to READ.
- DONE: done_o=1 for exactly one cycle; key_data_o cleared to 0; go to IDLE.
- Latency:
  - Request to first key_valid_o: 3 cycles (CHECK, READ, CAPT).
  - Back-to-back words with ready held high: 3 cycles per word.
  - done_o asserts 1 cycle after the last handshake.
- A new req_i is accepted in the cycle the FSM is back in IDLE, i.e. the cycle after done_o/err_o.
- key_ready_i while key_valid_o=0 is ignored.
- Index arithmetic is ADDR_W-bit. The underflow check guarantees cur_addr never wraps below 0.

Optional Feature:
- Macro FUSE_KEY_LOADER_LOCK_EN enables per-destination one-shot locking.
- When defined:
  - Add a 2^DEST_W-bit lock register, cleared only by reset.
  - Set the dest bit in DONE.
  - CHECK additionally rejects (err_o pulse, no reads) any command whose dest bit is set.
- When undefined: no lock register; a destination may be reloaded any number of times.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with req_i=1 -> all outputs 0, busy_o=0, no fuse_addr_o activity.
- Single load: req addr=7, len=2, dest=3; fuse[7]=32'h2b7e1516, fuse[6]=32'h28aed2a6; key_ready_i=1 -> two words, 32'h2b7e1516 then 32'h28aed2a6; key_dest_o=3; key_last_o only on the second; done_o 1 cycle after; fuse_addr_o sequence 7, 6.
- Backpressure: len=1, key_ready_i=0 for 5 cycles then 1 -> key_valid_o and key_data_o stable for all 6 cycles; a single handshake; done_o next cycle.
- Errors: req addr=2, len=4 (underflow); addr=108, len=1; len=0; len=17 -> each gives one err_o pulse 1 cycle after the request; key_valid_o stays 0; busy_o returns low.
- Reset mid-stream: len=4, assert rst_ni=0 while in SEND on word 2 -> key_valid_o=0 next edge; no done_o; a new request after reset completes normally.
- With FUSE_KEY_LOADER_LOCK_EN: load dest=5 succeeds; repeated load dest=5 -> err_o, no reads; load dest=4 succeeds; after reset, dest=5 succeeds again.
